// File: rtl/wallace_16bit_seq_multiplier_if.sv
// wallace_16bit_seq_multiplier_if: start/operand/result bundle for the sequential multiplier
interface wallace_16bit_seq_multiplier_if;
  logic start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic busy;
  logic done;
  logic [31:0] result;
  modport master(output start, multiplicand, multiplier, input busy, done, result);
  modport slave(input start, multiplicand, multiplier, output busy, done, result);
endinterface

// File: rtl/wallace_16bit_seq_multiplier.sv
// wallace_16bit_seq_multiplier: 16x16 unsigned multiply via one shared 8x8 Wallace array over four cycles
module wallace_8bit_multiplier (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    csa = {x ^ y ^ z, ((x & y) | (x & z) | (y & z)) << 1};
  endfunction
  for (genvar g = 0; g < 8; g++) begin : g_pp
    assign pp[g] = b[g] ? ({8'b0, a} << g) : 16'b0;
  end
  // 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add; the product fits 16 bits so carries past bit 15 are zero
  assign {s0, c0} = csa(pp[0], pp[1], pp[2]);
  assign {s1, c1} = csa(pp[3], pp[4], pp[5]);
  assign {s2, c2} = csa(s0, c0, s1);
  assign {s3, c3} = csa(c1, pp[6], pp[7]);
  assign {s4, c4} = csa(s2, c2, s3);
  assign {s5, c5} = csa(s4, c4, c3);
  assign p = s5 + c5;
endmodule

module wallace_16bit_seq_multiplier #(
  parameter int DATA_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  wallace_16bit_seq_multiplier_if.slave bus
);
  localparam int H = DATA_WIDTH / 2;
  localparam int W = 2 * DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic [W-1:0] acc_q, result_q, sum;
  logic [1:0] step_q;
  logic [H-1:0] a_sel, b_sel;
  logic [DATA_WIDTH-1:0] p;
  // step[1] picks the A half, step[0] the B half, so the mux depends only on registered state
  assign a_sel = step_q[1] ? a_q[DATA_WIDTH-1:H] : a_q[H-1:0];
  assign b_sel = step_q[0] ? b_q[DATA_WIDTH-1:H] : b_q[H-1:0];
  wallace_8bit_multiplier u_arr (.a(a_sel), .b(b_sel), .p(p));
  assign sum = acc_q + ({{DATA_WIDTH{1'b0}}, p} << (step_q == 2'd0 ? 5'd0 : step_q == 2'd3 ? 5'd16 : 5'd8));
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
  assign bus.result = result_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state: start only matters in IDLE, DONE always falls back to IDLE
  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (bus.start ? MUL : IDLE) : state_q == MUL ? (step_q == 2'd3 ? DONE : MUL) : IDLE;
  end
  // operand capture, accumulation and result load on the last step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      step_q <= '0;
      result_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      a_q <= bus.multiplicand;
      b_q <= bus.multiplier;
      acc_q <= '0;
      step_q <= '0;
    end else if (state_q == MUL) begin
      acc_q <= sum;
      step_q <= step_q + 2'd1;
      if (step_q == 2'd3) result_q <= sum;
    end
endmodule

// File: tb/tb_wallace_16bit_seq_multiplier.sv
// tb_wallace_16bit_seq_multiplier: directed checks of latency, results, back-to-back and abort
module tb_wallace_16bit_seq_multiplier;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] last_exp = 0;
  wallace_16bit_seq_multiplier_if m();
  wallace_16bit_seq_multiplier #(.DATA_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(m));
  always #5 clk = ~clk;

  task automatic test_reset();
    m.start = 1;
    m.multiplicand = 16'h0003;
    m.multiplier = 16'h0005;
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", m.busy); end
    checks++; if (m.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", m.done); end
    checks++; if (m.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", m.result); end
    m.start = 0;
    rst_n = 1;
    last_exp = 0;
  endtask

  task automatic run(input string nm, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp, input bit scramble);
    int busy_n, done_n, done_at;
    busy_n = 0; done_n = 0; done_at = 0;
    @(negedge clk);
    m.start = 1; m.multiplicand = a; m.multiplier = b;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      m.start = 0;
      if (scramble && i == 2) begin m.multiplicand = 16'hFFFF; m.multiplier = 16'h0001; end
      if (m.busy) busy_n++;
      if (m.done) begin done_n++; done_at = i; end
      if (i < 5) begin
        checks++; if (m.result !== last_exp) begin errors++; $display("FAIL %s hold@%0d got %h want %h", nm, i, m.result, last_exp); end
      end
      if (i == 5) begin
        checks++; if (m.result !== exp) begin errors++; $display("FAIL %s result got %h want %h", nm, m.result, exp); end
      end
    end
    checks++; if (busy_n != 5) begin errors++; $display("FAIL %s busy_cycles got %0d want 5", nm, busy_n); end
    checks++; if (done_n != 1 || done_at != 5) begin errors++; $display("FAIL %s done got count %0d at %0d want 1 at 5", nm, done_n, done_at); end
    checks++; if (m.result !== exp) begin errors++; $display("FAIL %s result_hold got %h want %h", nm, m.result, exp); end
    last_exp = exp;
  endtask

  task automatic test_basic();
    run("basic", 16'h0003, 16'h0005, 32'h0000000F, 0);
  endtask

  task automatic test_max();
    run("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0);
  endtask

  task automatic test_operand_change();
    run("opchange", 16'h1234, 16'h5678, 32'h06260060, 1);
  endtask

  task automatic test_back_to_back();
    int dn, first, prev;
    bit gap_bad, idle;
    dn = 0; first = 0; prev = 0; gap_bad = 0;
    @(negedge clk);
    m.start = 1; m.multiplicand = 16'h0100; m.multiplier = 16'h0100;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (m.done) begin
        dn++;
        if (dn == 1) first = i;
        else if (i - prev != 6) gap_bad = 1;
        prev = i;
        checks++; if (m.result !== 32'h00010000) begin errors++; $display("FAIL b2b result#%0d got %h want 00010000", dn, m.result); end
      end
    end
    checks++; if (dn != 3 || first != 5 || gap_bad) begin errors++; $display("FAIL b2b done got count %0d first %0d gapbad %0d want 3 5 0", dn, first, gap_bad); end
    m.start = 0;
    idle = 0;
    for (int i = 0; i < 12 && !idle; i++) begin
      @(negedge clk);
      idle = !m.busy;
    end
    checks++; if (!idle) begin errors++; $display("FAIL b2b drain got busy want idle"); end
    last_exp = 32'h00010000;
  endtask

  task automatic test_abort();
    bit saw_done;
    saw_done = 0;
    @(negedge clk);
    m.start = 1; m.multiplicand = 16'hFFFF; m.multiplier = 16'h0002;
    repeat (3) begin
      @(negedge clk);
      m.start = 0;
    end
    rst_n = 0;
    #1;
    checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", m.busy); end
    checks++; if (m.done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", m.done); end
    checks++; if (m.result !== 32'h0) begin errors++; $display("FAIL abort_result got %h want 0", m.result); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (m.done || m.busy) saw_done = 1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL abort_quiet got activity want idle"); end
    last_exp = 0;
    run("after_abort", 16'h0002, 16'h0007, 32'h0000000E, 0);
  endtask

  task automatic test_zero();
    run("zero", 16'h0000, 16'hABCD, 32'h00000000, 0);
  endtask

  initial begin
    m.start = 0;
    m.multiplicand = 0;
    m.multiplier = 0;
    test_reset();
    test_basic();
    test_max();
    test_operand_change();
    test_back_to_back();
    test_abort();
    test_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
